// File: rtl/miner_pkg.sv
// Shared definitions for the miner result path: UART frame layout and FSM encoding.
package miner_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam int         FRAME_BYTES       = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // Byte 0 of a frame is the sync header; bytes 1..4 walk the nonce MSB first.
    function automatic logic [7:0] nonce_byte(input logic [31:0] nonce, input logic [2:0] idx);
        case (idx)
            3'd1:    return nonce[31:24];
            3'd2:    return nonce[23:16];
            3'd3:    return nonce[15:8];
            default: return nonce[7:0];
        endcase
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO with registered read port; a pop on a full queue frees the slot for a same-cycle push.
module nonce_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH-1:0]      r_rd_data;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;

endmodule

// File: rtl/golden_nonce_uart_tx.sv
// Queues golden nonces and sends each as a 5-byte 8N1 frame (sync byte + nonce MSB first).
module golden_nonce_uart_tx
    import miner_pkg::*;
#(
    parameter int         CLKS_PER_BIT    = 434,
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
    input  logic                       hash_clk,
    input  logic                       reset,
    input  logic                       golden_valid,
    input  logic [31:0]                golden_nonce,
    output logic                       uart_tx,
    output logic                       busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(FRAME_BYTES - 1);

    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [2:0]        r_byte_idx;
    logic [2:0]        w_byte_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              r_busy;
    logic              r_overflow;
    logic [7:0]        r_drop_count;

    logic                     w_pop;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_drop;
    logic                     w_baud_done;
    logic [31:0]              w_shadow;
    logic [FIFO_DEPTH_LOG2:0] w_count;

    // The FIFO's registered read port doubles as the shadow copy of the nonce in flight.
    nonce_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (hash_clk),
        .rst       (reset),
        .i_push    (golden_valid),
        .i_wr_data (golden_nonce),
        .i_pop     (w_pop),
        .o_rd_data (w_shadow),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_drop      = golden_valid & w_full & ~w_pop;

    always_comb begin
        w_state_next    = r_state;
        w_baud_next     = r_baud;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        w_shift_next    = r_shift;
        w_pop           = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop           = 1'b1;
                    w_byte_idx_next = '0;
                    w_shift_next    = SYNC_BYTE;
                    w_baud_next     = '0;
                    w_state_next    = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_done) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_byte_idx < LAST_BYTE) begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                        w_shift_next    = nonce_byte(w_shadow, r_byte_idx + 1'b1);
                        w_state_next    = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_shift    <= w_shift_next;
        end
    end

    // Line level and busy are registered from the current state so both share one cycle of delay.
    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                ST_START: r_tx <= 1'b0;
                ST_DATA:  r_tx <= r_shift[0];
                default:  r_tx <= 1'b1;
            endcase
            r_busy <= (r_state != ST_IDLE) | (w_count != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 8'hFF) begin
                    r_drop_count <= r_drop_count + 8'd1;
                end
            end
        end
    end

    assign uart_tx    = r_tx;
    assign busy       = r_busy;
    assign fifo_count = w_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Randomised and directed bench: every cycle the DUT outputs are compared with a frame-level reference model.
module tb_golden_nonce_uart_tx;

    localparam int CPB       = 4;
    localparam int DEPTH_L2  = 2;
    localparam int DEPTH     = 1 << DEPTH_L2;
    localparam int FRAME_CYC = 50 * CPB;

    logic              hash_clk = 1'b0;
    logic              reset;
    logic              golden_valid;
    logic [31:0]       golden_nonce;
    logic              uart_tx;
    logic              busy;
    logic [DEPTH_L2:0] fifo_count;
    logic              overflow;
    logic [7:0]        drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_q[$];
    int          m_timer;
    int          m_txpos;
    logic [31:0] m_cur;
    logic        m_busy;
    logic        m_ovf;
    int          m_drops;
    int          n_frames = 0;

    golden_nonce_uart_tx #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DEPTH_L2),
        .SYNC_BYTE       (8'h55)
    ) dut (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .golden_valid (golden_valid),
        .golden_nonce (golden_nonce),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 hash_clk = ~hash_clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame bit k (0..49): ten bits per byte (start, 8 data LSB first, stop).
    function automatic logic exp_bit(input logic [31:0] n, input int k);
        int         b;
        int         p;
        logic [7:0] byt;
        b = k / 10;
        p = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        byt = (b == 0) ? 8'h55 : 8'((n >> (8 * (4 - b))) & 32'hFF);
        return byt[p-1];
    endfunction

    function automatic logic exp_tx();
        if (m_txpos >= 0 && m_txpos < FRAME_CYC) return exp_bit(m_cur, m_txpos / CPB);
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_timer = 0;
        m_txpos = FRAME_CYC;
        m_cur   = '0;
        m_busy  = 1'b0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // One clock edge: a frame takes FRAME_CYC cycles after its pop, then the link needs one idle cycle.
    task automatic model_edge(input logic v, input logic [31:0] n);
        int pre_size;
        logic pop;
        pre_size = m_q.size();
        pop      = (m_timer == 0) && (pre_size > 0);
        m_busy   = (m_timer > 0) || (pre_size > 0);
        if (pop) begin
            m_cur   = m_q.pop_front();
            m_txpos = -1;
            n_frames++;
            $display("[TB] frame %0d start nonce=%08h", n_frames, m_cur);
        end else if (m_txpos < FRAME_CYC) begin
            m_txpos++;
        end
        if (v) begin
            if (pre_size < DEPTH || pop) begin
                m_q.push_back(n);
            end else begin
                m_ovf = 1'b1;
                if (m_drops < 255) m_drops++;
                $display("[TB] drop nonce=%08h drops=%0d", n, m_drops);
            end
        end
        if (pop) m_timer = FRAME_CYC;
        else if (m_timer > 0) m_timer--;
    endtask

    task automatic check_outputs();
        check("uart_tx", uart_tx, exp_tx());
        check("busy", busy, m_busy);
        check("fifo_count", fifo_count, m_q.size());
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_drops);
    endtask

    task automatic step(input logic v, input logic [31:0] n);
        golden_valid = v;
        golden_nonce = n;
        @(posedge hash_clk);
        model_edge(v, n);
        #1;
        check_outputs();
        golden_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, $urandom);
    endtask

    initial begin
        int i;
        reset        = 1'b1;
        golden_valid = 1'b0;
        golden_nonce = '0;
        model_reset();
        repeat (2) @(posedge hash_clk);
        #1;
        check_outputs();
        reset = 1'b0;
        #1;
        check_outputs();

        // Basic frame, then an all-zero nonce
        step(1'b1, 32'h1234ABCD);
        idle(FRAME_CYC + 10);
        step(1'b1, 32'h00000000);
        idle(FRAME_CYC + 10);

        // Queue order: three back-to-back strobes
        step(1'b1, 32'hA41F32E7);
        step(1'b1, 32'h00000001);
        step(1'b1, 32'hFFFFFFFF);
        idle(3 * FRAME_CYC + 20);

        // Fill queue during a frame, then push exactly on the pop edge
        step(1'b1, 32'h11111111);
        step(1'b1, 32'h22222222);
        step(1'b1, 32'h33333333);
        step(1'b1, 32'h44444444);
        step(1'b1, 32'h55555555);
        for (i = 0; i < 2 * FRAME_CYC && m_timer != 0; i++) step(1'b0, 32'h0);
        check("pop_wait_bound", m_timer, 0);
        step(1'b1, 32'h66666666);
        check("simul_count", fifo_count, 4);
        check("simul_ovf", overflow, 0);
        idle(5 * FRAME_CYC + 20);

        // Overflow: seven strobes while idle
        for (i = 0; i < 7; i++) step(1'b1, 32'hC0DE0000 + i);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 2);
        idle(5 * FRAME_CYC + 20);

        // Saturation of the drop counter
        for (i = 0; i < 300; i++) step(1'b1, $urandom);
        check("drop_sat", drop_count, 255);
        idle(5 * FRAME_CYC + 20);

        // Reset in the middle of byte 2's data bits, with entries still queued
        step(1'b1, 32'h00000000);
        step(1'b1, 32'hDEADBEEF);
        step(1'b1, 32'hCAFEF00D);
        for (i = 0; i < FRAME_CYC && m_txpos != 22 * CPB + 1; i++) step(1'b0, 32'h0);
        check("rst_wait_bound", m_txpos, 22 * CPB + 1);
        check("tx_before_rst", uart_tx, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rst_tx", uart_tx, 1);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_drops", drop_count, 0);
        model_reset();
        @(posedge hash_clk);
        #1;
        reset = 1'b0;
        check_outputs();
        step(1'b1, 32'h89ABCDEF);
        idle(FRAME_CYC + 10);

        // Random traffic
        for (i = 0; i < 3000; i++) step($urandom_range(0, 99) < 3, $urandom);
        idle(6 * FRAME_CYC + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/golden_nonce_uart_tx.md
Name: golden_nonce_uart_tx

Overview:
- Result-reporting end of the miner-to-host path: accepts golden-nonce pulses from the miner control unit and queues them.
- Serialises each queued nonce to the host as a framed 8N1 UART byte stream.
- Replaces the JTAG probe readout with a pin-level link, so results are never lost between host polls.
- Sits in the top level between the golden-nonce register and a GPIO TX pin.

Parameters:
- CLKS_PER_BIT, 434, hash_clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH_LOG2, 2, log2 of nonce queue depth (default 4 entries).
- SYNC_BYTE, 8'h55, header byte sent before each nonce.

Ports:
- hash_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- golden_valid  in  1  single-cycle strobe; a new golden nonce is present.
- golden_nonce  in  32  nonce value, sampled when golden_valid=1.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  high while a frame is in flight or the queue is non-empty.
- fifo_count  out  FIFO_DEPTH_LOG2+1  number of queued nonces, excluding the frame in flight.
- overflow  out  1  sticky; set when a nonce is dropped.
- drop_count  out  8  dropped-nonce counter; saturates at 255.

Behaviour:
- Reset (async assert, sync release) values: uart_tx=1, busy=0, fifo_count=0, overflow=0, drop_count=0, FSM=IDLE, queue empty.
- Frame format: 5 bytes, in order SYNC_BYTE, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0].
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame duration: 50*CLKS_PER_BIT cycles. Bytes within a frame are back-to-back, with no idle gap.
- Queue: synchronous FIFO of 32-bit entries; push on golden_valid.
  - Pop occurs when the FSM is in IDLE and the queue is non-empty. The popped word is loaded into a 32-bit shadow register.
- FSM states: IDLE, START, DATA, STOP. It tracks byte_idx 0..4, bit_idx 0..7 and a baud counter of width clog2(CLKS_PER_BIT).
  - IDLE: uart_tx=1. If non-empty: pop, byte_idx=0, load shift reg=SYNC_BYTE, go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: uart_tx=shift[0]. After each bit period, shift right. After bit_idx 7, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<4: byte_idx++, load the next nonce byte from the shadow register, go to START.
    - Else: go to IDLE.
- Latency: golden_valid sampled at edge N with FSM idle and queue empty → pop at edge N+1 → uart_tx falls after edge N+2.
- Consecutive frames: at least one IDLE cycle of uart_tx=1 between the last stop bit and the next start bit.
- Full queue, push with no pop in the same cycle: nonce dropped, overflow←1, drop_count++ (saturating). Queue contents are unchanged.
- Full queue, push and pop in the same cycle: push accepted; fifo_count is unchanged.
- Frame in flight is independent of the queue; effective capacity is 2^FIFO_DEPTH_LOG2 + 1 nonces.
- golden_valid held high for several cycles: each high cycle is a separate push. The upstream must pulse it.
- Reset mid-frame: uart_tx returns high immediately. The partial frame is abandoned and the queue is flushed. The host resynchronises on SYNC_BYTE.
- busy = (FSM≠IDLE) | (fifo_count≠0), registered-equivalent. It must not glitch to 0 between frames when entries remain.

Decomposition:
- Shared package (miner_pkg): SYNC_BYTE default, UART FSM state encoding, FRAME_BYTES=5 constant.
- Sub-module nonce_fifo: parameterised by width and depth; ports push/pop/full/empty/count. It is reusable for a later host→miner work-receive path.
- The UART FSM and baud counter stay in this module.

Test Plan:
- Basic frame (CLKS_PER_BIT=4): pulse golden_valid with 32'h1234ABCD → uart_tx decodes bytes 55,12,34,AB,CD.
  - Start bit begins 2 cycles after the strobe.
  - Frame spans exactly 200 cycles; busy falls the cycle after the final stop bit.
- Bit timing (CLKS_PER_BIT=7): nonce 32'h00000000 → each 0 bit is exactly 7 cycles.
  - Stop bits are 7 cycles high; no gap between bytes; total 350 cycles.
- Queue order: 3 strobes on consecutive cycles with 32'hA41F32E7, 32'h00000001, 32'hFFFFFFFF → three frames in that order.
  - Each is separated by ≥1 idle cycle; fifo_count steps 0→1→2→1→0.
- Overflow (depth 4): 7 strobes on consecutive cycles while idle → 5 frames transmitted (1 in flight + 4 queued).
  - overflow=1, drop_count=2; the first five nonces are the ones sent.
- Simultaneous push/pop: fill the queue to 4 during a frame; at the exact cycle the FSM pops, strobe a new nonce.
  - Nonce accepted, fifo_count stays 4, overflow remains 0.
- Reset mid-frame: assert reset during DATA of byte 2 → uart_tx=1 within the same cycle (async), fifo_count=0, overflow=0.
  - After release, a new strobe produces a clean full frame.
